// File: rtl/trace_pkg.sv
// Shared definitions for the output-port trace monitor: run-state encoding
// and the record-width helpers that size the holding registers and FIFO.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } trace_state_e;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int rec_width(input int ts_w, input int channels, input int data_w);
    return ts_w + ch_width(channels) + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; head is presented
// combinationally and forced to zero while empty.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags, accepted push/pop and head presentation
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    count     = wr_ptr_r - rd_ptr_r;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (empty) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/oport_trace_monitor.sv
// Timestamps output-port strobes into per-channel holding registers, drains
// them by fixed priority into a trace FIFO, and tracks run/halted/timeout.
module oport_trace_monitor
  import trace_pkg::*;
#(
  parameter int  DATA_W   = 8,
  parameter int  CHANNELS = 1,
  parameter int  DEPTH    = 16,
  parameter int  TS_W     = 16,
  parameter int  TIMEOUT  = 0,
  localparam int CW       = ch_width(CHANNELS),
  localparam int REC_W    = rec_width(TS_W, CHANNELS, DATA_W),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        go,
  input  logic [CHANNELS*DATA_W-1:0] oport,
  input  logic                       halt,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [REC_W-1:0]           rd_data,
  output logic [CNT_W-1:0]           count,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic [1:0]                 state
);

  localparam int            IW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TO_V = IW'(TIMEOUT);

  trace_state_e        st_r;
  logic [TS_W-1:0]     ts_r;
  logic [IW-1:0]       idle_r;
  logic [IW-1:0]       idle_nxt_s;
  logic [CHANNELS-1:0] hold_v_r;
  logic [REC_W-1:0]    hold_r [CHANNELS];
  logic                overflow_r;
  logic [7:0]          drop_count_r;

  logic                run_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;
  logic                pop_s;
  logic                can_drain_s;
  logic                found_s;
  logic                push_s;
  logic [REC_W-1:0]    push_data_s;
  logic [CHANNELS-1:0] drain_sel_s;
  logic [CHANNELS-1:0] drained_s;
  logic [CHANNELS-1:0] accept_s;
  logic [CHANNELS-1:0] drop_s;
  logic [3:0]          ndrop_s;
  logic [8:0]          drop_sum_s;
  logic                timeout_hit_s;

  // Priority drain, strobe acceptance/drop decisions and counter next-values
  always_comb begin
    run_s       = (st_r == ST_RUN);
    pop_s       = rd_en && !fifo_empty_s;
    can_drain_s = !fifo_full_s || pop_s;
    found_s     = 1'b0;
    push_data_s = '0;
    drain_sel_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (hold_v_r[i] && !found_s) begin
        drain_sel_s[i] = 1'b1;
        push_data_s    = hold_r[i];
        found_s        = 1'b1;
      end else begin
        drain_sel_s[i] = 1'b0;
      end
    end
    push_s    = found_s && can_drain_s;
    drained_s = drain_sel_s & {CHANNELS{can_drain_s}};
    accept_s  = go & {CHANNELS{run_s}} & (~hold_v_r | drained_s);
    drop_s    = go & {CHANNELS{run_s}} & hold_v_r & ~drained_s;
    ndrop_s   = 4'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      ndrop_s = ndrop_s + {3'd0, drop_s[i]};
    end
    drop_sum_s = {1'b0, drop_count_r} + {5'd0, ndrop_s};
    if (|accept_s) begin
      idle_nxt_s = '0;
    end else if (idle_r == TO_V) begin
      idle_nxt_s = idle_r;
    end else begin
      idle_nxt_s = idle_r + {{(IW-1){1'b0}}, 1'b1};
    end
    timeout_hit_s = (TIMEOUT != 0) && (idle_nxt_s == TO_V);
  end

  // Channel holding registers: capture on accepted strobe, clear on drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v_r <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept_s[i]) begin
          hold_r[i]   <= {ts_r, CW'(i), oport[i*DATA_W +: DATA_W]};
          hold_v_r[i] <= 1'b1;
        end else if (drained_s[i]) begin
          hold_v_r[i] <= 1'b0;
        end
      end
    end
  end

  // Run-state machine with timestamp and idle counters; halt beats timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_r   <= ST_RUN;
      ts_r   <= '0;
      idle_r <= '0;
    end else begin
      case (st_r)
        ST_RUN: begin
          ts_r   <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
          idle_r <= idle_nxt_s;
          if (halt) begin
            st_r <= ST_HALTED;
          end else if (timeout_hit_s) begin
            st_r <= ST_TIMEOUT;
          end
        end
        ST_HALTED, ST_TIMEOUT: begin
          st_r <= st_r;
        end
        default: begin
          st_r <= ST_HALTED;
        end
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      overflow_r <= overflow_r || (|drop_s);
      if (drop_sum_s[8]) begin
        drop_count_r <= 8'hFF;
      end else begin
        drop_count_r <= drop_sum_s[7:0];
      end
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (rd_en),
    .head      (rd_data),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (count)
  );

  assign rd_valid   = !fifo_empty_s;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;
  assign state      = st_r;

endmodule

// File: tb/tb_oport_trace_monitor.sv
// Scoreboard bench: a two-channel, depth-4 instance without watchdog and a
// single-channel instance with TIMEOUT=10, sharing clock and reset.
module tb_oport_trace_monitor;

  localparam int RW = 25;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    go_a;
  logic [15:0]   oport_a;
  logic          halt_a, rd_en_a, rd_valid_a, overflow_a;
  logic [RW-1:0] rd_data_a;
  logic [2:0]    count_a;
  logic [7:0]    drop_a;
  logic [1:0]    state_a;

  logic          go_b, halt_b, rd_en_b, rd_valid_b, overflow_b;
  logic [7:0]    oport_b;
  logic [RW-1:0] rd_data_b;
  logic [4:0]    count_b;
  logic [7:0]    drop_b;
  logic [1:0]    state_b;

  oport_trace_monitor #(.DATA_W(8), .CHANNELS(2), .DEPTH(4), .TS_W(16), .TIMEOUT(0)) u_a (
    .clk(clk), .reset(reset), .go(go_a), .oport(oport_a), .halt(halt_a), .rd_en(rd_en_a),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .count(count_a), .overflow(overflow_a),
    .drop_count(drop_a), .state(state_a));

  oport_trace_monitor #(.DATA_W(8), .CHANNELS(1), .DEPTH(16), .TS_W(16), .TIMEOUT(10)) u_b (
    .clk(clk), .reset(reset), .go(go_b), .oport(oport_b), .halt(halt_b), .rd_en(rd_en_b),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .count(count_b), .overflow(overflow_b),
    .drop_count(drop_b), .state(state_b));

  int            checks = 0;
  int            errors = 0;
  int            popped = 0;
  logic [RW-1:0] sb[$];
  logic [RW-1:0] mon_exp;
  logic [15:0]   ts_m = 16'd0;
  bit            run_m = 1'b1;

  // Scoreboard: every pop of instance A is compared against the expected queue
  always @(negedge clk) begin
    if (reset && rd_en_a && rd_valid_a) begin
      checks++;
      popped++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got %h want none", rd_data_a);
      end else begin
        mon_exp = sb.pop_front();
        if (rd_data_a !== mon_exp) begin
          errors++;
          $display("FAIL record got %h want %h", rd_data_a, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  task automatic step();
    @(posedge clk);
    if (run_m) ts_m = ts_m + 16'd1;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    go_a = 2'b00; oport_a = 16'h0000; halt_a = 1'b0; rd_en_a = 1'b0;
    go_b = 1'b0; oport_b = 8'h00; halt_b = 1'b0; rd_en_b = 1'b0;
    sb.delete();
    popped = 0;
    ts_m = 16'd0;
    run_m = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", rd_valid_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count_a); end
    checks++; if (rd_data_a !== 25'd0) begin errors++; $display("FAIL rst_rd_data got %h want 0", rd_data_a); end
    checks++; if (overflow_a !== 1'b0 || drop_a !== 8'd0) begin errors++; $display("FAIL rst_drop got %b/%0d want 0/0", overflow_a, drop_a); end
    checks++; if (state_a !== 2'd0 || state_b !== 2'd0) begin errors++; $display("FAIL rst_state got %0d/%0d want 0/0", state_a, state_b); end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] d;
    do_reset();
    rd_en_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      go_a = 2'b00;
      if (k == 3 || k == 4 || k == 10) begin
        d = (k == 3) ? 8'h05 : (k == 4) ? 8'h0A : 8'hFF;
        go_a = 2'b01;
        oport_a = {8'h00, d};
        sb.push_back({ts_m, 1'b0, d});
      end
      step();
      if (k == 3) begin
        checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL single_latency_early got %b want 0", rd_valid_a); end
      end
      if (k == 4) begin
        checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", rd_valid_a); end
      end
    end
    go_a = 2'b00;
    checks++; if (popped != 3 || sb.size() != 0) begin errors++; $display("FAIL single_count got %0d left %0d want 3 left 0", popped, sb.size()); end
  endtask

  task automatic test_dual();
    logic [RW-1:0] r0, r1;
    do_reset();
    rd_en_a = 1'b1;
    r0 = {16'd5, 1'b0, 8'h11};
    r1 = {16'd5, 1'b1, 8'h22};
    for (int k = 0; k < 10; k++) begin
      go_a = 2'b00;
      if (k == 5) begin
        go_a = 2'b11;
        oport_a = 16'h2211;
        sb.push_back(r0);
        sb.push_back(r1);
      end
      step();
      if (k == 6) begin
        checks++; if (rd_data_a !== r0) begin errors++; $display("FAIL dual_first got %h want %h", rd_data_a, r0); end
      end
      if (k == 7) begin
        checks++; if (rd_data_a !== r1) begin errors++; $display("FAIL dual_second got %h want %h", rd_data_a, r1); end
      end
    end
    checks++; if (drop_a !== 8'd0 || overflow_a !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL dual_nodrop got %0d/%b left %0d want 0/0 left 0", drop_a, overflow_a, sb.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      go_a = 2'b01;
      oport_a = {8'h00, 8'(k + 1)};
      if (k < 5) sb.push_back({ts_m, 1'b0, 8'(k + 1)});
      step();
    end
    go_a = 2'b00;
    step();
    checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count_a); end
    checks++; if (overflow_a !== 1'b1 || drop_a !== 8'd1) begin errors++; $display("FAIL ovf_drop got %b/%0d want 1/1", overflow_a, drop_a); end
    rd_en_a = 1'b1;
    step();
    rd_en_a = 1'b0;
    checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL ovf_refill got %0d want 4", count_a); end
    rd_en_a = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    step();
    rd_en_a = 1'b0;
    checks++; if (sb.size() != 0 || count_a !== 3'd0 || rd_valid_a !== 1'b0) begin errors++; $display("FAIL ovf_drain got left %0d count %0d want 0 0", sb.size(), count_a); end
    checks++; if (drop_a !== 8'd1) begin errors++; $display("FAIL ovf_drop_hold got %0d want 1", drop_a); end
  endtask

  task automatic test_no_timeout();
    do_reset();
    for (int k = 0; k < 40; k++) step();
    checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL no_timeout got %0d want 0", state_a); end
  endtask

  task automatic test_halt();
    do_reset();
    rd_en_a = 1'b1;
    for (int k = 0; k < 26; k++) begin
      halt_a = (k >= 20 && k < 23);
      go_a = 2'b00;
      if (k == 20) begin
        go_a = 2'b01; oport_a = 16'h005A;
        sb.push_back({ts_m, 1'b0, 8'h5A});
      end
      if (k == 21) begin
        go_a = 2'b01; oport_a = 16'h00A5;
      end
      step();
      if (k == 19) begin
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL halt_pre got %0d want 0", state_a); end
      end
      if (k == 20) begin
        run_m = 1'b0;
        checks++; if (state_a !== 2'd1) begin errors++; $display("FAIL halt_state got %0d want 1", state_a); end
      end
    end
    go_a = 2'b00; halt_a = 1'b0;
    checks++; if (state_a !== 2'd1 || drop_a !== 8'd0) begin errors++; $display("FAIL halt_terminal got %0d/%0d want 1/0", state_a, drop_a); end
    checks++; if (popped != 1 || sb.size() != 0 || rd_valid_a !== 1'b0) begin errors++; $display("FAIL halt_records got %0d want 1", popped); end
  endtask

  task automatic test_timeout();
    logic [RW-1:0] r;
    do_reset();
    r = {16'd2, 1'b0, 8'h3C};
    for (int k = 0; k < 15; k++) begin
      go_b = (k == 2);
      oport_b = 8'h3C;
      step();
      if (k == 11) begin
        checks++; if (state_b !== 2'd0) begin errors++; $display("FAIL timeout_early got %0d want 0", state_b); end
      end
      if (k == 12) begin
        checks++; if (state_b !== 2'd2) begin errors++; $display("FAIL timeout_state got %0d want 2", state_b); end
      end
    end
    checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== r) begin errors++; $display("FAIL timeout_record got %h want %h", rd_data_b, r); end
    go_b = 1'b1;
    step();
    go_b = 1'b0;
    step();
    rd_en_b = 1'b1;
    step();
    rd_en_b = 1'b0;
    checks++; if (rd_valid_b !== 1'b0 || count_b !== 5'd0 || drop_b !== 8'd0) begin errors++; $display("FAIL timeout_ignore got %b/%0d/%0d want 0/0/0", rd_valid_b, count_b, drop_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      go_a = (k < 3) ? 2'b01 : 2'b00;
      oport_a = {8'h00, 8'(8'h40 + k)};
      step();
    end
    halt_a = 1'b1;
    step();
    halt_a = 1'b0;
    checks++; if (count_a !== 3'd3 || state_a !== 2'd1) begin errors++; $display("FAIL mid_pre got %0d/%0d want 3/1", count_a, state_a); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (count_a !== 3'd0 || rd_valid_a !== 1'b0) begin errors++; $display("FAIL mid_flush got %0d/%b want 0/0", count_a, rd_valid_a); end
    checks++; if (state_a !== 2'd0 || rd_data_a !== 25'd0) begin errors++; $display("FAIL mid_state got %0d/%h want 0/0", state_a, rd_data_a); end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    go_a = 2'b00; oport_a = 16'h0000; halt_a = 1'b0; rd_en_a = 1'b0;
    go_b = 1'b0; oport_b = 8'h00; halt_b = 1'b0; rd_en_b = 1'b0;
    test_reset();
    test_single();
    test_dual();
    test_overflow();
    test_no_timeout();
    test_halt();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
